if_prefetch_unit: RTL and testbench
===================================

Name: if_prefetch_unit

Overview:
Parametrised instruction-fetch stage that replaces the single-register PC and IF/ID latch. It issues pipelined requests to instruction memory through a valid/ready handshake, and buffers in-order responses in a DEPTH-entry queue. It presents {pc, instr, pc+4} to decode through a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses.

Parameters:
ADDR_W, 32, PC and instruction-memory address width
INSTR_W, 32, instruction word width
DEPTH, 4, queue entries and maximum outstanding requests; power of 2, >=2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
boot_pc_i  in  ADDR_W  PC loaded on reset
imem_req_valid_o  out  1  fetch request valid
imem_req_addr_o  out  ADDR_W  fetch address
imem_req_ready_i  in  1  memory accepts request
imem_resp_valid_i  in  1  in-order response valid; no backpressure
imem_resp_data_i  in  INSTR_W  instruction word
redirect_valid_i  in  1  branch/jump taken; flush
redirect_pc_i  in  ADDR_W  new fetch PC
id_valid_o  out  1  queue head valid
id_instr_o  out  INSTR_W  head instruction
id_pc_o  out  ADDR_W  head PC
id_pc_plus4_o  out  ADDR_W  head PC + 4
id_ready_i  in  1  decode accepts head (deasserted on load-use stall)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - fetch_pc = resp_pc = boot_pc_i with bits [1:0] forced to 0.
  - occupancy = outstanding = discard = 0.
  - imem_req_valid_o = 0 and id_valid_o = 0 during rst and in the first cycle after it.
- Request issue:
  - imem_req_valid_o = !rst && !redirect_valid_i && (occupancy + outstanding < DEPTH). This credit rule guarantees queue space for every response.
  - imem_req_addr_o = fetch_pc.
  - On valid && ready: fetch_pc += 4 (mod 2^ADDR_W) and outstanding++.
  - Once asserted, valid stays asserted with a stable address until ready, unless a redirect occurs.
- Response handling:
  - Every response decrements outstanding.
  - If discard > 0: drop the response, discard--.
  - Otherwise: push {resp_pc, data} to the queue and resp_pc += 4.
  - A response while outstanding == 0 is a protocol violation. It is ignored and flagged by assertion.
- Dequeue:
  - id_valid_o = (occupancy != 0); outputs are registered queue-head fields.
  - Pop on id_valid_o && id_ready_i.
  - Simultaneous push and pop is legal at any occupancy.
- Latency: a response in cycle N gives id_valid_o in cycle N+1. There is no bypass.
- Redirect (highest priority):
  - In the redirect cycle, no request is issued and any pop is void.
  - Next state: occupancy = 0, fetch_pc = resp_pc = redirect_pc_i & ~3.
  - discard = outstanding after this cycle's events, i.e. a response arriving in the redirect cycle is dropped and not counted.
  - Back-to-back redirects: the latest wins; discard is recomputed each time.
- Reset mid-operation: all counters clear. Responses for pre-reset requests are the memory's responsibility; memory is reset with the same rst.
- Wrap: PC addition wraps modulo 2^ADDR_W. Counters are clog2(DEPTH)+1 bits wide.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds two outputs, perf_bubble_cnt_o[31:0] and perf_flush_cnt_o[31:0]. Both reset to 0 and saturate at 2^32-1.
  - perf_bubble_cnt_o counts cycles with !rst && !id_valid_o.
  - perf_flush_cnt_o counts cycles with redirect_valid_i.
- Undefined: the ports and their logic are absent. Core behaviour is identical either way.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {pc[ADDR_W], instr[INSTR_W]}.
  - PC_STEP = 4.
  - CNT_W(depth) = clog2(depth)+1.
- Sub-module fetch_queue: synchronous FIFO with push, pop and a flush that dominates both. It uses wrap-around read/write pointers and an occupancy count.

Test Plan:
1. Reset with boot_pc_i=0x140, ready=1, 1-cycle memory: requests go to 0x140, 0x144, 0x148, … in consecutive cycles. Decode receives pc=0x140, pc_plus4=0x144 first, in order, with no gaps.
2. id_ready_i=0 held, DEPTH=4: exactly 4 requests issue, then imem_req_valid_o=0. Raising ready resumes issue one cycle after the first pop.
3. 3-cycle memory with 3 outstanding, then redirect to 0x200: next id_valid_o shows pc=0x200. The three stale responses never appear, and discard returns to 0.
4. Redirect in the same cycle as a response and a pop: the response is dropped, no entry is consumed, the queue is empty next cycle, and discard = remaining outstanding.
5. imem_req_ready_i toggling 1,0,0,1: address stays stable while stalled, with no duplicate or skipped PCs.
6. fetch_pc=0xFFFFFFFC: next request address is 0x00000000. With FETCH_PERF_CNT_EN, 2 redirects give perf_flush_cnt_o=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and helpers for the instruction prefetch unit
package fetch_pkg;

  localparam int ENTRY_ADDR_W  = 32;
  localparam int ENTRY_INSTR_W = 32;
  localparam int PC_STEP       = 4;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0]  pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Counters must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// rtl/if_prefetch_unit_if.sv - instruction-memory and decode handshakes of the prefetch unit
interface if_prefetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  logic               imem_req_valid_o;
  logic [ADDR_W-1:0]  imem_req_addr_o;
  logic               imem_req_ready_i;
  logic               imem_resp_valid_i;
  logic [INSTR_W-1:0] imem_resp_data_i;
  logic               id_valid_o;
  logic [INSTR_W-1:0] id_instr_o;
  logic [ADDR_W-1:0]  id_pc_o;
  logic [ADDR_W-1:0]  id_pc_plus4_o;
  logic               id_ready_i;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i,
    output id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
    input  id_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i,
    input  id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
    output id_ready_i
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO with push, pop and a flush that dominates both
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head_data,
  output logic [cnt_w(DEPTH)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CW-1:0]    occ_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is left unreset; occupancy alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = mem[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - pipelined instruction prefetch with redirect flush
// Optional perf counters behind FETCH_PERF_CNT_EN.
module if_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  boot_pc_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  if_prefetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_bubble_cnt_o,
  output logic [31:0]        perf_flush_cnt_o
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(PC_STEP - 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] resp_pc_q;
  logic [CW-1:0]     outstanding_q;
  logic [CW-1:0]     discard_q;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     occupancy;
  logic [CW:0]       credits_used;
  logic              booted_q;
  logic              req_valid;
  logic              req_fire;
  logic              resp_fire;
  logic              resp_keep;
  logic              id_valid;
  logic              pop;
  entry_t            push_entry;
  entry_t            head_entry;

  // Credits cover queued plus in-flight words, so every response has a slot.
  always_comb begin
    credits_used    = {1'b0, occupancy} + {1'b0, outstanding_q};
    req_valid       = !rst && booted_q && !redirect_valid_i &&
                      (credits_used < (CW+1)'(DEPTH));
    req_fire        = req_valid && bus.imem_req_ready_i;
    resp_fire       = bus.imem_resp_valid_i && (outstanding_q != '0);
    resp_keep       = resp_fire && (discard_q == '0) && !redirect_valid_i;
    id_valid        = !rst && (occupancy != '0);
    pop             = id_valid && bus.id_ready_i && !redirect_valid_i;
    outstanding_nxt = outstanding_q + CW'(req_fire) - CW'(resp_fire);
    push_entry.pc    = resp_pc_q;
    push_entry.instr = bus.imem_resp_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= boot_pc_i & PC_MASK;
      resp_pc_q     <= boot_pc_i & PC_MASK;
      outstanding_q <= '0;
      discard_q     <= '0;
      booted_q      <= 1'b0;
    end else begin
      booted_q      <= 1'b1;
      outstanding_q <= outstanding_nxt;
      if (redirect_valid_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc_q <= redirect_pc_i & PC_MASK;
        resp_pc_q  <= redirect_pc_i & PC_MASK;
        discard_q  <= outstanding_nxt;
      end else begin
        if (req_fire)  fetch_pc_q <= fetch_pc_q + PC_INC;
        if (resp_keep) resp_pc_q  <= resp_pc_q + PC_INC;
        if (resp_fire && (discard_q != '0)) discard_q <= discard_q - CW'(1);
      end
    end
  end

  fetch_queue #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid_i),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .occupancy (occupancy)
  );

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = fetch_pc_q;
  assign bus.id_valid_o       = id_valid;
  assign bus.id_instr_o       = head_entry.instr;
  assign bus.id_pc_o          = head_entry.pc;
  assign bus.id_pc_plus4_o    = head_entry.pc + PC_INC;

  resp_without_request: assert property (
    @(posedge clk) disable iff (rst) !(bus.imem_resp_valid_i && (outstanding_q == '0))
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt_o <= '0;
      perf_flush_cnt_o  <= '0;
    end else begin
      if (!id_valid && (perf_bubble_cnt_o != '1)) perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
      if (redirect_valid_i && (perf_flush_cnt_o != '1)) perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - self-checking bench for if_prefetch_unit with an epoch-based fetch model
module tb_if_prefetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] boot_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble;
  logic [31:0] perf_flush;
`endif

  if_prefetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  if_prefetch_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .boot_pc_i        (boot_pc),
    .redirect_valid_i (redirect),
    .redirect_pc_i    (redirect_pc),
    .bus              (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt_o (perf_bubble),
    .perf_flush_cnt_o  (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } infl_t;

  fetch_entry_t mq[$];
  infl_t        infl[$];
  int           epoch = 0;
  int           cyc = 0;
  int           lat = 1;
  logic         booted = 1'b0;
  logic [31:0]  m_fetch_pc = '0;
  int           dut_acc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  logic        s_req_valid, s_id_valid;
  logic [31:0] s_req_addr, s_id_pc, s_id_pc4, s_id_instr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: memory drives, outputs are compared to the model, model advances.
  task automatic step();
    logic         resp_drv;
    infl_t        resp_e;
    logic         exp_req_valid;
    logic         exp_id_valid;
    fetch_entry_t e;
    resp_drv = 1'b0;
    resp_e   = '{addr: '0, epoch: 0, due: 0};
    if (!rst && infl.size() > 0 && infl[0].due <= cyc) begin
      resp_e   = infl.pop_front();
      resp_drv = 1'b1;
    end
    bus.imem_resp_valid_i = resp_drv;
    bus.imem_resp_data_i  = resp_drv ? mem_data(resp_e.addr) : 32'h0;
    @(negedge clk);
    s_req_valid = bus.imem_req_valid_o;
    s_req_addr  = bus.imem_req_addr_o;
    s_id_valid  = bus.id_valid_o;
    s_id_pc     = bus.id_pc_o;
    s_id_pc4    = bus.id_pc_plus4_o;
    s_id_instr  = bus.id_instr_o;

    exp_req_valid = !rst && booted && !redirect &&
                    (mq.size() + infl.size() + int'(resp_drv) < DEPTH);
    exp_id_valid  = !rst && (mq.size() != 0);
    chk($sformatf("req_valid c%0d", cyc), {31'b0, s_req_valid}, {31'b0, exp_req_valid});
    if (exp_req_valid) chk($sformatf("req_addr c%0d", cyc), s_req_addr, m_fetch_pc);
    chk($sformatf("id_valid c%0d", cyc), {31'b0, s_id_valid}, {31'b0, exp_id_valid});
    if (exp_id_valid) begin
      chk($sformatf("id_pc c%0d", cyc), s_id_pc, mq[0].pc);
      chk($sformatf("id_pc4 c%0d", cyc), s_id_pc4, mq[0].pc + 32'd4);
      chk($sformatf("id_instr c%0d", cyc), s_id_instr, mq[0].instr);
    end

    if (rst) begin
      mq.delete();
      infl.delete();
      booted     = 1'b0;
      m_fetch_pc = boot_pc & ~32'd3;
      epoch++;
      dut_acc    = 0;
    end else begin
      if (exp_id_valid && bus.id_ready_i && !redirect) void'(mq.pop_front());
      if (resp_drv && !redirect && resp_e.epoch == epoch) begin
        e.pc    = resp_e.addr;
        e.instr = mem_data(resp_e.addr);
        mq.push_back(e);
      end
      if (exp_req_valid && bus.imem_req_ready_i) begin
        infl.push_back('{addr: m_fetch_pc, epoch: epoch, due: cyc + lat});
        m_fetch_pc += 32'd4;
      end
      if (s_req_valid && bus.imem_req_ready_i) dut_acc++;
      if (redirect) begin
        mq.delete();
        m_fetch_pc = redirect_pc & ~32'd3;
        epoch++;
      end
      booted = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    boot_pc = pc;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_id(input string name, input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!s_id_valid && n < max);
    if (!s_id_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: id_valid not seen within %0d cycles", name, max);
    end
  endtask

  logic [31:0] t5_addr [5] = '{32'h300, 32'h304, 32'h304, 32'h304, 32'h308};
  logic        t5_rdy  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int          gapless;

  initial begin
    rst = 1'b1;
    boot_pc = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    bus.imem_req_ready_i  = 1'b1;
    bus.imem_resp_valid_i = 1'b0;
    bus.imem_resp_data_i  = '0;
    bus.id_ready_i        = 1'b1;
    @(posedge clk);
    #1;

    // 1: streaming from boot PC with a 1-cycle memory
    lat = 1;
    do_reset(32'h140);
    step();
    chk("t1_no_req_after_rst", {31'b0, s_req_valid}, 32'd0);
    step();
    chk("t1_first_req", s_req_addr, 32'h140);
    step();
    chk("t1_second_req", s_req_addr, 32'h144);
    step();
    chk("t1_first_id_pc", s_id_pc, 32'h140);
    chk("t1_first_id_pc4", s_id_pc4, 32'h144);
    chk("t1_first_instr", s_id_instr, 32'h5A5A_C283);
    gapless = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      gapless += int'(s_id_valid);
    end
    chk("t1_no_gaps", gapless, 32'd20);

    // 2: decode stalled, credits exhaust at DEPTH
    bus.id_ready_i = 1'b0;
    do_reset(32'h140);
    repeat (10) step();
    chk("t2_accepts", dut_acc, 32'd4);
    chk("t2_req_blocked", {31'b0, s_req_valid}, 32'd0);
    bus.id_ready_i = 1'b1;
    step();
    chk("t2_pop_cycle_no_req", {31'b0, s_req_valid}, 32'd0);
    step();
    chk("t2_resume_req", {31'b0, s_req_valid}, 32'd1);
    repeat (6) step();

    // 3: redirect with three requests in flight on a 3-cycle memory
    lat = 3;
    do_reset(32'h1000);
    repeat (4) step();
    chk("t3_outstanding", dut_acc, 32'd3);
    redirect = 1'b1;
    redirect_pc = 32'h201;
    step();
    redirect = 1'b0;
    wait_id("t3_wait", 30);
    chk("t3_target_pc", s_id_pc, 32'h200);
    step();
    chk("t3_next_pc", s_id_pc, 32'h204);
    repeat (8) step();

    // 4: redirect coinciding with a response and a pop
    lat = 1;
    do_reset(32'h400);
    repeat (6) step();
    redirect = 1'b1;
    redirect_pc = 32'h500;
    step();
    redirect = 1'b0;
    chk("t4_pop_attempted", {31'b0, s_id_valid}, 32'd1);
    step();
    chk("t4_empty_after", {31'b0, s_id_valid}, 32'd0);
    wait_id("t4_wait", 20);
    chk("t4_target_pc", s_id_pc, 32'h500);
    repeat (4) step();

    // 5: memory ready toggling holds the address steady
    do_reset(32'h303);
    step();
    for (int k = 0; k < 5; k++) begin
      bus.imem_req_ready_i = t5_rdy[k];
      step();
      chk($sformatf("t5_addr%0d", k), s_req_addr, t5_addr[k]);
    end
    bus.imem_req_ready_i = 1'b1;
    repeat (6) step();

    // 6: back-to-back redirects, last one near the top of the address space
    do_reset(32'h0);
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h1234;
    step();
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("t6_flush_cnt", perf_flush, 32'd2);
`endif
    step();
    chk("t6_wrap_req0", s_req_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_wrap_req1", s_req_addr, 32'h0000_0000);
    step();
    chk("t6_wrap_id_pc", s_id_pc, 32'hFFFF_FFFC);
    chk("t6_wrap_id_pc4", s_id_pc4, 32'h0000_0000);
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
